// File: rtl/abc_sweep_sequencer.sv
// Sweeps {a,b,c} through all 8 codes, samples x/y/z per code and builds truth-table words.
// Define SWEEP_GRAY_ORDER_EN to sweep in Gray-code order (tables are identical either way).
module abc_sweep_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic [2:0] step,
  output logic [7:0] table_x,
  output logic [7:0] table_y,
  output logic [7:0] table_z
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned STEP_W   = 3;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Input code applied at a given step of the sweep.
  function automatic logic [STEP_W-1:0] code_of(input logic [STEP_W-1:0] k);
`ifdef SWEEP_GRAY_ORDER_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // Tables are written at the current {a,b,c}, so they are independent of sweep order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      step    <= '0;
      {a, b, c} <= 3'b000;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_x <= '0;
      table_y <= '0;
      table_z <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            step      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            table_x   <= '0;
            table_y   <= '0;
            table_z   <= '0;
            {a, b, c} <= code_of('0);
            cnt       <= CNT_RELOAD;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            table_x[{a, b, c}] <= x;
            table_y[{a, b, c}] <= y;
            table_z[{a, b, c}] <= z;
            if (step == LAST_STEP) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= 3'b000;
            end else begin
              step      <= step + STEP_W'(1);
              {a, b, c} <= code_of(step + STEP_W'(1));
              cnt       <= CNT_RELOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abc_sweep_sequencer.sv
// Directed bench for abc_sweep_sequencer: HOLD_CYCLES=2 instance plus a HOLD_CYCLES=1 instance,
// both driving a modelled downstream block x=a&b, y=a|c, z=a^b^c.
module tb_abc_sweep_sequencer;

  localparam int unsigned HOLD  = 2;
  localparam int unsigned SWEEP = 8 * HOLD;
  localparam logic [7:0] EXP_X = 8'hC0;
  localparam logic [7:0] EXP_Y = 8'hFA;
  localparam logic [7:0] EXP_Z = 8'h96;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic       a, b, c, x, y, z, busy, done;
  logic [2:0] step;
  logic [7:0] table_x, table_y, table_z;
  logic       a1, b1, c1, x1, y1, z1, busy1, done1;
  logic [2:0] step1;
  logic [7:0] table_x1, table_y1, table_z1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign x  = a & b;
  assign y  = a | c;
  assign z  = a ^ b ^ c;
  assign x1 = a1 & b1;
  assign y1 = a1 | c1;
  assign z1 = a1 ^ b1 ^ c1;

  abc_sweep_sequencer #(.HOLD_CYCLES(HOLD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .step(step),
    .table_x(table_x), .table_y(table_y), .table_z(table_z)
  );

  abc_sweep_sequencer #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .step(step1),
    .table_x(table_x1), .table_y(table_y1), .table_z(table_z1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected input code for step k, written out by hand.
  function automatic logic [2:0] exp_code(input int k);
`ifdef SWEEP_GRAY_ORDER_EN
    case (k)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b011;
      3: return 3'b010;
      4: return 3'b110;
      5: return 3'b111;
      6: return 3'b101;
      default: return 3'b100;
    endcase
`else
    return 3'(k);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, step, a, b, c} of the main instance
  function automatic logic [31:0] ctl();
    return 32'({busy, done, step, a, b, c});
  endfunction

  task automatic check_tables(input string tag);
    check({tag, "_tx"}, 32'(table_x), 32'(EXP_X));
    check({tag, "_ty"}, 32'(table_y), 32'(EXP_Y));
    check({tag, "_tz"}, 32'(table_z), 32'(EXP_Z));
  endtask

  // Full monitored sweep; start is additionally pulsed before edges p1 and p2 (0 = none).
  task automatic run_sweep(input string tag, input int p1, input int p2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_accept"}, ctl(), 32'({1'b1, 1'b0, 3'd0, exp_code(0)}));
    check({tag, "_clr"}, 32'({table_x, table_y, table_z}), 32'(0));
    for (int n = 1; n <= int'(SWEEP); n++) begin
      start = (n == p1 || n == p2) ? 1'b1 : 1'b0;
      tick();
      start = 1'b0;
      if (n < int'(SWEEP))
        check($sformatf("%s_e%0d", tag, n), ctl(),
              32'({1'b1, 1'b0, 3'(n / int'(HOLD)), exp_code(n / int'(HOLD))}));
      else
        check($sformatf("%s_end", tag), ctl(), 32'({1'b0, 1'b1, 3'd7, 3'b000}));
    end
    check_tables(tag);
    tick();
    check({tag, "_hold"}, ctl(), 32'({1'b0, 1'b1, 3'd7, 3'b000}));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    tick();
    tick();
    check("reset_ctl", ctl(), 32'(0));
    check("reset_tab", 32'({table_x, table_y, table_z}), 32'(0));
    rst_n = 1'b1;
    tick();
    check("idle_ctl", ctl(), 32'(0));

    // Tests 1-2: plain sweep, every edge monitored
    run_sweep("t1", 0, 0);

    // Test 3: start during step 3 and on the final sample edge is ignored
    run_sweep("t3", 7, int'(SWEEP));

    // Test 4: async reset at step 5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 5 * int'(HOLD); n++) tick();
    check("t4_step5", 32'(step), 32'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_ctl", ctl(), 32'(0));
    check("t4_async_tab", 32'({table_x, table_y, table_z}), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t4_idle", ctl(), 32'(0));
    run_sweep("t4", 0, 0);

    // Test 5: start held high -> back-to-back sweeps
    start = 1'b1;
    tick();
    for (int n = 1; n <= int'(SWEEP); n++) tick();
    check("t5_done1", ctl(), 32'({1'b0, 1'b1, 3'd7, 3'b000}));
    check_tables("t5a");
    tick();
    check("t5_acc2", ctl(), 32'({1'b1, 1'b0, 3'd0, exp_code(0)}));
    check("t5_clr2", 32'({table_x, table_y, table_z}), 32'(0));
    for (int n = 1; n < int'(SWEEP); n++) tick();
    check("t5_run2", 32'({busy, done}), 32'(2'b10));
    tick();
    check("t5_done2", ctl(), 32'({1'b0, 1'b1, 3'd7, 3'b000}));
    check_tables("t5b");
    tick();
    check("t5_acc3", 32'({busy, done}), 32'(2'b10));
    start = 1'b0;
    for (int n = 0; n < int'(SWEEP); n++) tick();
    check("t5_done3", 32'({busy, done}), 32'(2'b01));

    // Test 6: HOLD_CYCLES=1 instance, new code every clock
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t6_accept", 32'({busy1, done1, step1, a1, b1, c1}), 32'({1'b1, 1'b0, 3'd0, exp_code(0)}));
    for (int n = 1; n < 8; n++) begin
      tick();
      check($sformatf("t6_e%0d", n), 32'({busy1, done1, step1, a1, b1, c1}),
            32'({1'b1, 1'b0, 3'(n), exp_code(n)}));
    end
    tick();
    check("t6_end", 32'({busy1, done1, step1, a1, b1, c1}), 32'({1'b0, 1'b1, 3'd7, 3'b000}));
    check("t6_tx", 32'(table_x1), 32'(EXP_X));
    check("t6_ty", 32'(table_y1), 32'(EXP_Y));
    check("t6_tz", 32'(table_z1), 32'(EXP_Z));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
